// File: rtl/uart_rx_oversampled.sv
// UART receiver paced by an oversampling tick; 2-flop rx synchroniser,
// mid-bit start validation, 3-sample majority vote per bit, optional parity.
// Ports:
//   in_clk      system clock, rising edge
//   rst         asynchronous active-low reset
//   baud_tick   1-cycle pulse, OVERSAMPLE per bit period
//   rx          asynchronous serial line, idle high
//   data        last received word (LSB first on the line)
//   data_valid  1-cycle strobe per completed frame
//   parity_err  parity mismatch, qualified by data_valid
//   frame_err   stop bit sampled low, qualified by data_valid
//   busy        high from accepted start edge until return to idle
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 in_clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP0 = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] SMP1 = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 smp_a;
    logic                 smp_b;
    logic                 perr_i;
    logic                 ferr_i;
    logic                 done;
    logic                 vote;
    logic                 par_exp;

    // The third sample is the live synchronised line at the last tick.
    assign vote    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign par_exp = par_acc ^ (PARITY == 2);

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            armed      <= 1'b1;
            shreg      <= '0;
            par_acc    <= 1'b0;
            smp_a      <= 1'b0;
            smp_b      <= 1'b0;
            perr_i     <= 1'b0;
            ferr_i     <= 1'b0;
            done       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Frame results are published one clock after the stop tick,
            // independent of whether the next tick has arrived.
            done       <= 1'b0;
            data_valid <= done;
            if (done) begin
                data       <= shreg;
                parity_err <= perr_i;
                frame_err  <= ferr_i;
            end

            if (baud_tick) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt == SMP0) smp_a <= rx_s;
                if (cnt == SMP1) smp_b <= rx_s;

                unique case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state   <= S_START;
                            busy    <= 1'b1;
                            perr_i  <= 1'b0;
                            ferr_i  <= 1'b0;
                            par_acc <= 1'b0;
                        end
                    end

                    S_START: begin
                        if (cnt == MID) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_DATA;
                                idx   <= '0;
                            end
                        end
                    end

                    S_DATA: begin
                        if (cnt == LAST) begin
                            shreg   <= {vote, shreg[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ vote;
                            idx     <= idx + 1'b1;
                            if (idx == LAST_BIT) begin
                                state <= (PARITY != 0) ? S_PAR : S_STOP;
                            end
                        end
                    end

                    S_PAR: begin
                        if (cnt == LAST) begin
                            if (vote != par_exp) perr_i <= 1'b1;
                            state <= S_STOP;
                        end
                    end

                    S_STOP: begin
                        if (cnt == LAST) begin
                            // A low stop bit may be a break; require the
                            // line to go high before the next start.
                            if (!vote) begin
                                ferr_i <= 1'b1;
                                armed  <= 1'b0;
                            end
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: three instances (no/even/odd parity)
// with a scoreboard queue per instance, checked on every data_valid.
module tb_uart_rx_oversampled;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       in_clk = 1'b0;
    logic       rst;
    logic       baud_tick = 1'b0;
    logic       rx0;
    logic       rx_p;
    logic [7:0] dat  [3];
    logic       dv   [3];
    logic       perr [3];
    logic       ferr [3];
    logic       busy [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t mon_e;

    int   n_pass = 0;
    int   n_total = 0;
    int   tph = 0;
    logic busy_d1 [3];
    logic busy_d2 [3];
    logic busy_seen = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_oversampled #(
            .DATA_BITS (8),
            .PARITY    (g),
            .OVERSAMPLE(16)
        ) u_dut (
            .in_clk    (in_clk),
            .rst       (rst),
            .baud_tick (baud_tick),
            .rx        ((g == 0) ? rx0 : rx_p),
            .data      (dat[g]),
            .data_valid(dv[g]),
            .parity_err(perr[g]),
            .frame_err (ferr[g]),
            .busy      (busy[g])
        );
    end

    always #5 in_clk = ~in_clk;

    // One tick every 4 clocks.
    always @(negedge in_clk) begin
        tph = (tph + 1) % 4;
        baud_tick = (tph == 0);
    end

    function automatic int qsize(input int g);
        case (g)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int g);
        case (g)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push(input int g, input logic [7:0] d,
                        input logic pe, input logic fe);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe};
        case (g)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge in_clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst === 1'b1 && dv[g] === 1'b1) begin
                n_total++;
                assert (qsize(g) != 0) begin
                    n_pass++;
                end else begin
                    $error("FAIL unexpected_valid dut%0d got data=%h expected no valid",
                           g, dat[g]);
                end
                if (qsize(g) != 0) begin
                    mon_e = qpop(g);
                    n_total++;
                    assert ({dat[g], perr[g], ferr[g]} === mon_e) begin
                        n_pass++;
                    end else begin
                        $error("FAIL frame dut%0d got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                               g, dat[g], perr[g], ferr[g],
                               mon_e.d, mon_e.pe, mon_e.fe);
                    end
                end
                if (g == 0) begin
                    n_total++;
                    assert ({busy_d2[0], busy_d1[0]} === 2'b10) begin
                        n_pass++;
                    end else begin
                        $error("FAIL busy_fall got=%b%b expected=10",
                               busy_d2[0], busy_d1[0]);
                    end
                end
            end
            if (g == 0 && busy[0] === 1'b1) busy_seen = 1'b1;
            busy_d2[g] = busy_d1[g];
            busy_d1[g] = busy[g];
        end
    end

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else rx_p = v;
    endtask

    task automatic hold(input int sel, input logic v, input int n);
        set_rx(sel, v);
        repeat (n) @(negedge in_clk);
    endtask

    // 64 clocks per bit; optional 4-clock inverted glitch at noise_at.
    task automatic send_bit(input int sel, input logic v, input int noise_at);
        if (noise_at < 0) begin
            hold(sel, v, 64);
        end else begin
            hold(sel, v, noise_at);
            hold(sel, ~v, 4);
            hold(sel, v, 60 - noise_at);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, input int par,
                        input logic stop, input bit noisy);
        send_bit(sel, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            send_bit(sel, d[i], noisy ? 20 + 4 * i : -1);
        end
        if (par >= 0) send_bit(sel, par[0], -1);
        send_bit(sel, stop, -1);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < limit) begin
            @(negedge in_clk);
            n++;
        end
        check(tag, 16'(q0.size() + q1.size() + q2.size()), 16'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        for (int g = 0; g < 3; g++) begin
            check(tag, {4'd0, dat[g], dv[g], perr[g], ferr[g], busy[g]}, 16'd0);
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            busy_d1[g] = 1'b0;
            busy_d2[g] = 1'b0;
        end
        rst  = 1'b0;
        rx0  = 1'b1;
        rx_p = 1'b1;
        repeat (5) @(negedge in_clk);
        check_reset_outs("reset_outs");
        rst = 1'b1;
        hold(0, 1'b1, 128);

        push(0, 8'h55, 1'b0, 1'b0);
        send(0, 8'h55, -1, 1'b1, 1'b0);
        wait_drain("drain_55", 400);
        hold(0, 1'b1, 64);

        push(0, 8'hA3, 1'b0, 1'b0);
        push(0, 8'h0F, 1'b0, 1'b0);
        send(0, 8'hA3, -1, 1'b1, 1'b0);
        send(0, 8'h0F, -1, 1'b1, 1'b0);
        wait_drain("drain_b2b", 400);
        hold(0, 1'b1, 64);

        busy_seen = 1'b0;
        hold(0, 1'b0, 20);
        hold(0, 1'b1, 256);
        check("glitch_busy_seen", {15'd0, busy_seen}, 16'd1);
        check("glitch_busy_low", {15'd0, busy[0]}, 16'd0);
        push(0, 8'h3C, 1'b0, 1'b0);
        send(0, 8'h3C, -1, 1'b1, 1'b0);
        wait_drain("drain_3c", 400);
        hold(0, 1'b1, 64);

        push(1, 8'h07, 1'b0, 1'b0);
        push(2, 8'h07, 1'b1, 1'b0);
        send(1, 8'h07, 1, 1'b1, 1'b0);
        wait_drain("drain_par1", 400);
        hold(1, 1'b1, 64);
        push(1, 8'h07, 1'b1, 1'b0);
        push(2, 8'h07, 1'b0, 1'b0);
        send(1, 8'h07, 0, 1'b1, 1'b0);
        wait_drain("drain_par0", 400);
        hold(1, 1'b1, 64);

        push(0, 8'h5A, 1'b0, 1'b1);
        send(0, 8'h5A, -1, 1'b0, 1'b0);
        hold(0, 1'b0, 192);
        wait_drain("drain_break", 10);
        check("break_no_restart", {15'd0, busy[0]}, 16'd0);
        hold(0, 1'b1, 64);
        push(0, 8'h81, 1'b0, 1'b0);
        send(0, 8'h81, -1, 1'b1, 1'b0);
        wait_drain("drain_81", 400);
        hold(0, 1'b1, 64);

        hold(0, 1'b0, 64);
        hold(0, 1'b1, 100);
        rst = 1'b0;
        @(negedge in_clk);
        check_reset_outs("midframe_reset_outs");
        hold(0, 1'b1, 8);
        rst = 1'b1;
        hold(0, 1'b1, 128);
        check("post_reset_idle", {15'd0, busy[0]}, 16'd0);
        push(0, 8'h12, 1'b0, 1'b0);
        send(0, 8'h12, -1, 1'b1, 1'b1);
        wait_drain("drain_12_noise", 400);
        hold(0, 1'b1, 128);

        check("final_queues", 16'(q0.size() + q1.size() + q2.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
